// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : sequential signed multiply / restoring divide, one bit per clk
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             div0_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             stall_q, done_q, div0_q, ovf_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;

  logic [WIDTH-1:0]   a_mag_d, b_mag_d;
  logic [WIDTH:0]     sum_d, trial_d;
  logic               ge_d;
  logic [WIDTH-1:0]   step_hi_d, step_lo_d;
  logic [2*WIDTH-1:0] prod_d;
  logic               neg_d;
  logic [WIDTH-1:0]   fix_lo_d, fix_hi_d;
  logic               fix_ovf_d;

  // The datapath works on magnitudes; signs are restored in FIX.
  always_comb begin
    a_mag_d   = a_i[WIDTH-1] ? -a_i : a_i;
    b_mag_d   = b_q[WIDTH-1] ? -b_q : b_q;
    sum_d     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_d} : '0);
    trial_d   = {hi_q, lo_q[WIDTH-1]};
    ge_d      = trial_d >= {1'b0, b_mag_d};
    step_hi_d = '0;
    step_lo_d = '0;
    if (op_q) begin
      step_hi_d = ge_d ? (trial_d[WIDTH-1:0] - b_mag_d) : trial_d[WIDTH-1:0];
      step_lo_d = {lo_q[WIDTH-2:0], ge_d};
    end else begin
      step_hi_d = sum_d[WIDTH:1];
      step_lo_d = {sum_d[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    neg_d     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod_d    = neg_d ? -{hi_q, lo_q} : {hi_q, lo_q};
    fix_lo_d  = '0;
    fix_hi_d  = '0;
    fix_ovf_d = 1'b0;
    if (op_q) begin
      fix_lo_d  = neg_d ? -lo_q : lo_q;
      fix_hi_d  = a_q[WIDTH-1] ? -hi_q : hi_q;
      fix_ovf_d = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    end else begin
      fix_lo_d  = prod_d[WIDTH-1:0];
      fix_hi_d  = prod_d[2*WIDTH-1:WIDTH];
      fix_ovf_d = prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            op_q   <= op_i;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a_mag_d;
            ovf_q  <= 1'b0;
            if (op_i && (b_i == '0)) begin
              res_lo_q <= '0;
              res_hi_q <= '0;
              div0_q   <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              div0_q   <= 1'b0;
              stall_q  <= 1'b1;
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort_i) begin
            stall_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q  <= step_hi_d;
            lo_q  <= step_lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          stall_q <= 1'b0;
          if (abort_i) begin
            state_q <= S_IDLE;
          end else begin
            res_lo_q <= fix_lo_d;
            res_hi_q <= fix_hi_d;
            ovf_q    <= fix_ovf_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o     = stall_q;
  assign done_o      = done_q;
  assign result_lo_o = res_lo_q;
  assign result_hi_o = res_hi_q;
  assign div0_o      = div0_q;
  assign overflow_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : scoreboard bench for muldiv_seq against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        d0;
    logic        ov;
  } exp_t;

  logic        clk, rst, start, op, abort;
  logic [15:0] a, b;
  logic        stall, done, div0, overflow;
  logic [15:0] res_lo, res_hi;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .abort_i(abort), .stall_o(stall), .done_o(done), .result_lo_o(res_lo),
    .result_hi_o(res_hi), .div0_o(div0), .overflow_o(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input bit o, input logic [15:0] x, input logic [15:0] y);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    if (!o) begin
      p    = sx * sy;
      e.lo = 16'(p);
      e.hi = 16'(p >>> 16);
      e.ov = (p > 32767) || (p < -32768);
    end else if (sy == 0) begin
      e.d0 = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.lo = 16'(q);
      e.hi = 16'(r);
      e.ov = (q > 32767) || (q < -32768);
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {res_lo, res_hi, div0, overflow}, {e.lo, e.hi, e.d0, e.ov});
      end
    end
  end

  task automatic do_op(input bit o, input logic [15:0] x, input logic [15:0] y, input int restart_at);
    exp_t e;
    int   n, stall_cnt, exp_lat;
    bit   seen;
    e = model(o, x, y);
    exp_lat = (o && (y == 16'h0)) ? 0 : 17;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
    n = 0; stall_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) stall_cnt++;
      start = (k == restart_at);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(n), 64'(exp_lat));
    chk("stall_cycles", 64'(stall_cnt), 64'(exp_lat));
    @(posedge clk);
    #1;
    chk("hold", {done, stall, res_lo, res_hi, div0, overflow}, {2'b00, e.lo, e.hi, e.d0, e.ov});
    last_exp = e;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0; a = '0; b = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {stall, done, res_lo, res_hi, div0, overflow}, 36'h0);
    rst = 1'b0;

    // First start lands on the first edge with rst low.
    do_op(1'b0, 16'd7, 16'hFFFD, -1);
    do_op(1'b0, 16'd300, 16'd300, -1);
    do_op(1'b0, 16'h8000, 16'h8000, -1);
    do_op(1'b1, 16'hFFF9, 16'd2, -1);
    do_op(1'b1, 16'd7, 16'hFFFE, -1);
    do_op(1'b1, 16'd5, 16'h0000, -1);
    do_op(1'b1, 16'h8000, 16'hFFFF, -1);
    do_op(1'b0, 16'h1234, 16'h0042, 3);

    // Abort at RUN step 5 after an op that raised overflow.
    do_op(1'b0, 16'd300, 16'd300, -1);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd9; b = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_stall", 64'(stall), 64'(0));
    repeat (25) @(posedge clk);
    #1;
    chk("abort_keep", {done, res_lo, res_hi, div0, overflow}, {1'b0, last_exp.lo, last_exp.hi, 2'b00});

    // Abort and start together in IDLE: start refused.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 1'b0; a = 16'd3; b = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", {stall, done}, 2'b00);

    // Reset between edges mid-RUN clears every output at once.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 16'd1000; b = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {stall, done, res_lo, res_hi, div0, overflow}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    do_op(1'b0, 16'hFF00, 16'h0123, -1);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] x, y;
      bit          o;
      int          sel;
      o   = 1'($urandom_range(0, 1));
      x   = 16'($urandom);
      y   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 16'h0000;
      if (sel == 1) begin x = 16'h8000; y = 16'hFFFF; end
      if (sel == 2) y = 16'($urandom_range(0, 3));
      do_op(o, x, y, (sel == 3) ? 5 : -1);
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 a  input  WIDTH  signed multiplicand / dividend, sampled with start.
REQ-007 b  input  WIDTH  signed multiplier / divisor, sampled with start.
REQ-008 abort  input  1  synchronous cancel of the operation in progress.
REQ-009 stall  output  1  high while an operation is in progress; holds pipeline fetch/decode.
REQ-010 done  output  1  one-cycle pulse, results and flags valid.
REQ-011 result_lo  output  WIDTH  product low half, or quotient.
REQ-012 result_hi  output  WIDTH  product high half, or remainder.
REQ-013 div0  output  1  divide-by-zero flag, feeds main control exception input.
REQ-014 overflow  output  1  result does not fit WIDTH signed, feeds main control exception input.

Function
REQ-015 States: IDLE, RUN, FIX, DONE; encoding left to implementer.
REQ-016 IDLE, start=1, edge E: latch a, b, op; clear div0/overflow; iteration counter := 0; go to RUN.
REQ-017 Exception: IDLE, start=1, op=1, b=0 at edge E: skip RUN/FIX; go to DONE; result_lo=result_hi=0; div0=1.
REQ-018 RUN: one shift-add (mul) or restoring shift-subtract (div) step on operand magnitudes per edge; after WIDTH steps (edge E+WIDTH) go to FIX.
REQ-019 FIX: apply signs at edge E+WIDTH+1 and go to DONE.
REQ-020 Result signs: product negative iff signs differ; quotient truncates toward zero; remainder takes sign of dividend.
REQ-021 DONE lasts exactly one cycle (done=1, stall=0), then IDLE; normal latency: done high in cycle after edge E+WIDTH+1 (17 cycles for WIDTH=16).
REQ-022 stall=1 exactly while in RUN or FIX; stall=0 in IDLE and DONE.
REQ-023 Multiply: overflow=1 iff result_hi is not the sign extension of result_lo[WIDTH-1]; full 2*WIDTH product still returned.
REQ-024 Divide: overflow=1 for a = most-negative, b = -1; result_lo = most-negative value (0x8000), result_hi = 0.
REQ-025 result_lo, result_hi, div0, overflow are registered and hold their values after DONE until the next accepted start.
REQ-026 start while in RUN, FIX or DONE is ignored and is not queued.
REQ-027 abort=1 in RUN or FIX: go to IDLE on next edge; no done; results and flags unchanged from before the aborted start, except div0/overflow, which stay cleared.
REQ-028 abort in IDLE or DONE has no effect; abort and start together in IDLE: abort wins, start is not accepted.
REQ-029 Operand inputs may change freely after the accepting edge; only latched copies are used.

Reset
REQ-030 rst=1 forces IDLE immediately, regardless of clk.
REQ-031 rst=1 clears to 0: counter, latched operands, stall, done, result_lo, result_hi, div0, overflow.
REQ-032 rst asserted mid-RUN/FIX: operation discarded; no done pulse after release.
REQ-033 First start is accepted on the first rising edge with rst low.

Verification
REQ-034 mul a=7, b=-3 (0xFFFD) -> done 17 cycles after accept; result_lo=0xFFEB, result_hi=0xFFFF, overflow=0; stall high for exactly 17 cycles.
REQ-035 mul 300*300 -> result_hi=0x0001, result_lo=0x5F90, overflow=1. mul 0x8000*0x8000 -> result_hi=0x4000, result_lo=0x0000, overflow=1.
REQ-036 div -7/2 -> result_lo=0xFFFD, result_hi=0xFFFF. div 7/-2 -> result_lo=0xFFFD, result_hi=0x0001. Both: overflow=0, div0=0.
REQ-037 div 5/0 -> done on the cycle after accept; div0=1, results 0, stall never high. div 0x8000/0xFFFF -> result_lo=0x8000, result_hi=0, overflow=1.
REQ-038 Start pulsed again during RUN -> ignored; only one done. abort at RUN step 5 -> IDLE next edge, no done, prior results retained.
REQ-039 rst asserted mid-RUN between clock edges -> all outputs 0 immediately. Next start after release -> normal 17-cycle completion.
